instr_encode: RTL and testbench
===============================

# instr_encode

Pipelined RISC-V RV32I instruction encoder. It packs decoded fields and a 32-bit immediate back into a 32-bit instruction word, laid out in the R/I/S/B/U/J formats. It is the inverse of the core's immediate decoder. It sits in the test and self-modifying-code path, feeding encoded words to the instruction-memory writer. Every immediate is checked for range and alignment, and a saturating error count is kept.

## Interface
- No parameters.
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- fmt  in  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6=I-shift, 7=invalid.
- opcode  in  7  copied to instr[6:0].
- rd, rs1, rs2  in  5 each  register fields.
- funct3  in  3  function field.
- funct7  in  7  function field (R, I-shift).
- imm  in  32  signed byte immediate (B/J: byte offset; U: value with low 12 bits zero).
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid && out_ready.
- out_instr  out  32  encoded word.
- out_err  out  3  {fmt_err, align_err, range_err}.
- err_count  out  16  number of results with any error bit set, saturating.

## Operation
- Two register stages, S1 and S2, each holding a valid bit.
- S1 captures the raw request on the input handshake.
- Encoding and checking are combinational from S1, and the result is registered into S2.
- S2 drives out_* directly.
- Encodings, MSB first:
  - R: funct7|rs2|rs1|funct3|rd|opcode.
  - I: imm[11:0]|rs1|funct3|rd|opcode.
  - I-shift: funct7|imm[4:0]|rs1|funct3|rd|opcode.
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode.
  - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode.
  - U: imm[31:12]|rd|opcode.
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode.
- range_err conditions:
  - I/S: imm[31:11] not all equal.
  - B: imm[31:12] not all equal.
  - J: imm[31:20] not all equal.
  - U: imm[11:0] != 0.
  - I-shift: imm[31:5] != 0.
  - R: never (imm ignored).
- align_err: B or J with imm[0]=1.
- fmt_err: fmt=7. out_instr is then forced to 32'h0000_0013 (NOP) and the other error bits are 0.
- On range or align errors the word is still emitted, built from the truncated fields above.
- err_count increments by 1 on each output handshake whose out_err != 0. It holds at 16'hFFFF.

## Timing
- Reset (asynchronous, immediate): S1/S2 valid=0, out_valid=0, out_instr=0, out_err=0, err_count=0.
- in_ready is 0 while reset_n is low.
- Any in-flight requests are dropped on reset. The first cycle after deassertion behaves as empty.
- S2 loads when !out_valid || out_ready.
- S1 loads when !S1.valid, or when S2 loads in the same cycle.
- in_ready = !S1.valid || (!out_valid || out_ready). This is a combinational path from out_ready; it is permitted.
- Latency: request accepted at edge k gives out_valid=1 from edge k+1. The result is visible in the cycle after k+1.
- Throughput is one word per cycle while out_ready=1.
- Simultaneous S2 drain and S1 refill in the same cycle is required. No bubbles, no loss, no duplication, order preserved.
- out_* are held stable while out_valid && !out_ready.
- Maximum buffering is 2. With out_ready=0, in_ready drops after the second accepted request.
- err_count updates on the same edge as the output handshake.

## Test plan
- I-type: fmt=1, opcode=0x13, rd=1, rs1=0, funct3=0, imm=0xFFFFFFFF -> out_instr=0xFFF00093, out_err=0, valid two edges after accept.
- B-type: fmt=3, opcode=0x63, rs1=1, rs2=2, funct3=0, imm=0xFFFFFFFC -> 0xFE208EE3. The same request with imm=0xFFFFFFFD -> align_err=1.
- J-type: fmt=5, opcode=0x6F, rd=1, imm=0x800 -> 0x001000EF. Then I-type with imm=0x800 -> 0x80000093, range_err=1, err_count=1.
- Backpressure: 5 back-to-back requests, out_ready=0 for 4 cycles then 1 -> only 2 accepted while stalled; all 5 emerge in order, none dropped or repeated.
- fmt=7 -> out_instr=0x00000013, out_err=3'b100.
- Saturation: preload 65536 error requests -> err_count stays at 0xFFFF.
- Reset mid-operation: both stages full, pulse reset_n low for a half cycle -> out_valid=0 and err_count=0 at once; the next request emerges after exactly 2 edges.

Source files
------------

// File: rtl/instr_encode.sv
// RV32I instruction encoder: packs decoded fields and an immediate into R/I/S/B/U/J words.
// Two-stage valid/ready pipeline (raw request in S1, encoded word and error flags in S2).
module instr_encode (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [2:0]  out_err,
    output logic [15:0] err_count
);

    // Handshake: a transfer happens on a rising edge where valid && ready are both high;
    // a producer holding valid keeps its payload stable until that edge.

    localparam logic [2:0] FMT_R  = 3'd0;
    localparam logic [2:0] FMT_I  = 3'd1;
    localparam logic [2:0] FMT_S  = 3'd2;
    localparam logic [2:0] FMT_B  = 3'd3;
    localparam logic [2:0] FMT_U  = 3'd4;
    localparam logic [2:0] FMT_J  = 3'd5;
    localparam logic [2:0] FMT_SH = 3'd6;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        s1_valid_q;
    logic [2:0]  s1_fmt_q;
    logic [6:0]  s1_opcode_q;
    logic [4:0]  s1_rd_q;
    logic [4:0]  s1_rs1_q;
    logic [4:0]  s1_rs2_q;
    logic [2:0]  s1_funct3_q;
    logic [6:0]  s1_funct7_q;
    logic [31:0] s1_imm_q;

    logic        out_valid_q;
    logic [31:0] out_instr_q;
    logic [2:0]  out_err_q;
    logic [15:0] err_count_q;
    logic [15:0] err_count_d;

    logic [31:0] enc_instr_d;
    logic [2:0]  enc_err_d;
    logic        s2_load;
    logic        s1_load;

    assign s2_load  = !out_valid_q || out_ready;
    assign s1_load  = !s1_valid_q || s2_load;
    assign in_ready = reset_n && s1_load;

    always_comb begin
        enc_instr_d = NOP;
        enc_err_d   = 3'b000;
        case (s1_fmt_q)
            FMT_R: enc_instr_d = {s1_funct7_q, s1_rs2_q, s1_rs1_q, s1_funct3_q, s1_rd_q, s1_opcode_q};
            FMT_I: begin
                enc_instr_d  = {s1_imm_q[11:0], s1_rs1_q, s1_funct3_q, s1_rd_q, s1_opcode_q};
                enc_err_d[0] = ~(&s1_imm_q[31:11] | ~|s1_imm_q[31:11]);
            end
            FMT_S: begin
                enc_instr_d  = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, s1_funct3_q,
                                s1_imm_q[4:0], s1_opcode_q};
                enc_err_d[0] = ~(&s1_imm_q[31:11] | ~|s1_imm_q[31:11]);
            end
            FMT_B: begin
                enc_instr_d  = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q, s1_funct3_q,
                                s1_imm_q[4:1], s1_imm_q[11], s1_opcode_q};
                enc_err_d[0] = ~(&s1_imm_q[31:12] | ~|s1_imm_q[31:12]);
                enc_err_d[1] = s1_imm_q[0];
            end
            FMT_U: begin
                enc_instr_d  = {s1_imm_q[31:12], s1_rd_q, s1_opcode_q};
                enc_err_d[0] = |s1_imm_q[11:0];
            end
            FMT_J: begin
                enc_instr_d  = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11], s1_imm_q[19:12],
                                s1_rd_q, s1_opcode_q};
                enc_err_d[0] = ~(&s1_imm_q[31:20] | ~|s1_imm_q[31:20]);
                enc_err_d[1] = s1_imm_q[0];
            end
            FMT_SH: begin
                enc_instr_d  = {s1_funct7_q, s1_imm_q[4:0], s1_rs1_q, s1_funct3_q,
                                s1_rd_q, s1_opcode_q};
                enc_err_d[0] = |s1_imm_q[31:5];
            end
            default: begin
                // Unknown format: emit a harmless NOP and flag only the format error.
                enc_instr_d = NOP;
                enc_err_d   = 3'b100;
            end
        endcase
    end

    always_comb begin
        err_count_d = err_count_q;
        if (out_valid_q && out_ready && (out_err_q != 3'b000) && (err_count_q != 16'hFFFF))
            err_count_d = err_count_q + 16'd1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q  <= 1'b0;
            s1_fmt_q    <= 3'd0;
            s1_opcode_q <= 7'd0;
            s1_rd_q     <= 5'd0;
            s1_rs1_q    <= 5'd0;
            s1_rs2_q    <= 5'd0;
            s1_funct3_q <= 3'd0;
            s1_funct7_q <= 7'd0;
            s1_imm_q    <= 32'd0;
        end else if (s1_load) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_fmt_q    <= fmt;
                s1_opcode_q <= opcode;
                s1_rd_q     <= rd;
                s1_rs1_q    <= rs1;
                s1_rs2_q    <= rs2;
                s1_funct3_q <= funct3;
                s1_funct7_q <= funct7;
                s1_imm_q    <= imm;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_instr_q <= 32'd0;
            out_err_q   <= 3'd0;
            err_count_q <= 16'd0;
        end else begin
            err_count_q <= err_count_d;
            if (s2_load) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    out_instr_q <= enc_instr_d;
                    out_err_q   <= enc_err_d;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_err   = out_err_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_instr_encode.sv
// Directed bench for instr_encode: hand-computed encodings, error flags, backpressure,
// error-counter saturation and mid-operation reset.
module tb_instr_encode;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  fmt = 3'd0;
    logic [6:0]  opcode = 7'd0;
    logic [4:0]  rd = 5'd0;
    logic [4:0]  rs1 = 5'd0;
    logic [4:0]  rs2 = 5'd0;
    logic [2:0]  funct3 = 3'd0;
    logic [6:0]  funct7 = 7'd0;
    logic [31:0] imm = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [2:0]  out_err;
    logic [15:0] err_count;

    int n_tests = 0;
    int n_fail  = 0;
    logic [15:0] exp_cnt = 16'd0;
    logic [31:0] exp_q[$];

    instr_encode dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
        .funct7(funct7), .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_err(out_err), .err_count(err_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                           input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [31:0] im);
        fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
    endtask

    // One isolated transaction with out_ready held high; checks latency, word, flags, counter.
    task automatic single(input string tag, input logic [31:0] exp_instr, input logic [2:0] exp_err);
        @(negedge clock);
        in_valid = 1'b1; out_ready = 1'b1;
        #1 check({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        #1 check({tag, ".lat0"}, {31'd0, out_valid}, 32'd0);
        @(posedge clock);
        @(negedge clock);
        #1 check({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, ".instr"}, out_instr, exp_instr);
        check({tag, ".err"}, {29'd0, out_err}, {29'd0, exp_err});
        if (exp_err != 3'b000 && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        @(posedge clock);
        @(negedge clock);
        #1 check({tag, ".cnt"}, {16'd0, err_count}, {16'd0, exp_cnt});
        check({tag, ".drained"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        int sent, got, stall_acc;
        // reset state
        #7;
        check("rst.out_valid", {31'd0, out_valid}, 32'd0);
        check("rst.out_instr", out_instr, 32'd0);
        check("rst.out_err", {29'd0, out_err}, 32'd0);
        check("rst.err_count", {16'd0, err_count}, 32'd0);
        check("rst.in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        set_req(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
        single("i_neg1", 32'hFFF0_0093, 3'b000);
        set_req(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC);
        single("b_m4", 32'hFE20_8EE3, 3'b000);
        set_req(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800);
        single("j_800", 32'h0010_00EF, 3'b000);
        set_req(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800);
        single("i_range", 32'h8000_0093, 3'b001);
        set_req(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFD);
        single("b_align", 32'hFE20_8EE3, 3'b010);
        set_req(3'd0, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 32'hDEAD_BEEF);
        single("r_sub", 32'h4031_00B3, 3'b000);
        set_req(3'd2, 7'h23, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 32'hFFFF_FFFC);
        single("s_sw", 32'hFE51_2E23, 3'b000);
        set_req(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
        single("u_lui", 32'h1234_52B7, 3'b000);
        set_req(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001);
        single("u_range", 32'h1234_52B7, 3'b001);
        set_req(3'd6, 7'h13, 5'd1, 5'd2, 5'd0, 3'd5, 7'h20, 32'h0000_0003);
        single("sh_srai", 32'h4031_5093, 3'b000);
        set_req(3'd6, 7'h13, 5'd1, 5'd2, 5'd0, 3'd5, 7'h20, 32'h0000_0023);
        single("sh_range", 32'h4031_5093, 3'b001);
        set_req(3'd7, 7'h33, 5'd7, 5'd7, 5'd7, 3'd7, 7'h7F, 32'h0000_0800);
        single("fmt7", 32'h0000_0013, 3'b100);
        set_req(3'd5, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFF0_0000);
        single("j_min", 32'h8000_006F, 3'b000);
        set_req(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F800);
        single("i_min", 32'h8000_0093, 3'b000);

        // backpressure: five requests, out_ready low for the first four cycles
        for (int i = 1; i <= 5; i++) exp_q.push_back((32'(i) << 20) | 32'h0000_0093);
        sent = 0; got = 0; stall_acc = 0;
        for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
            @(negedge clock);
            out_ready = (cyc >= 4);
            in_valid = (sent < 5);
            set_req(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'(sent + 1));
            #1;
            if (out_valid && out_ready) begin
                check("bp.order", out_instr, exp_q.pop_front());
                got++;
            end else if (out_valid) begin
                check("bp.hold", out_instr, exp_q[0]);
            end
            if (in_valid && in_ready) begin
                sent++;
                if (cyc < 4) stall_acc++;
            end
            @(posedge clock);
        end
        @(negedge clock);
        in_valid = 1'b0;
        #1 check("bp.got", 32'(got), 32'd5);
        check("bp.stall_acc", 32'(stall_acc), 32'd2);
        check("bp.no_dup", {31'd0, out_valid}, 32'd0);
        check("bp.cnt", {16'd0, err_count}, {16'd0, exp_cnt});

        // saturation: stream far more error results than the counter can hold
        set_req(3'd7, 7'h00, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        in_valid = 1'b1; out_ready = 1'b1;
        repeat (65540) @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        #1 check("sat.cnt", {16'd0, err_count}, 32'h0000_FFFF);
        exp_cnt = 16'hFFFF;
        single("sat.more", 32'h0000_0013, 3'b100);

        // reset with both stages full
        @(negedge clock);
        out_ready = 1'b0; in_valid = 1'b1;
        set_req(3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7);
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        #1 check("mr.full_valid", {31'd0, out_valid}, 32'd1);
        check("mr.full_ready", {31'd0, in_ready}, 32'd0);
        reset_n = 1'b0;
        #1 check("mr.out_valid", {31'd0, out_valid}, 32'd0);
        check("mr.err_count", {16'd0, err_count}, 32'd0);
        check("mr.in_ready", {31'd0, in_ready}, 32'd0);
        check("mr.out_instr", out_instr, 32'd0);
        #2 reset_n = 1'b1;
        exp_cnt = 16'd0;
        @(negedge clock);
        #1 check("mr.empty", {31'd0, out_valid}, 32'd0);
        set_req(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800);
        single("mr.next", 32'h8000_0093, 3'b001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
